// File: rtl/serial_subtractor4.sv
// Bit-serial subtractor: diff = a - b - bin, processed LSB first, one bit per clock.
// Operands are captured on a start/done handshake; results hold until the next DONE.
module serial_subtractor4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam int             MSB  = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:1]  r_sh;
    logic              r_br;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_diff;
    logic              r_borrow;
    logic              r_ovf;

    logic              w_accept;
    logic              w_last;
    logic              w_abit;
    logic              w_bbit;
    logic              w_dbit;
    logic              w_br_nxt;
    logic [WIDTH-1:0]  w_result;

    // A new operation may start from IDLE or directly out of the DONE cycle.
    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_cnt == LAST);

    assign w_abit   = r_a[r_cnt];
    assign w_bbit   = r_b[r_cnt];
    assign w_dbit   = w_abit ^ w_bbit ^ r_br;
    assign w_br_nxt = (~w_abit & w_bbit) | (~(w_abit ^ w_bbit) & r_br);

    // The LSB that would fall out of the right-shifting result register is never
    // needed, so only the upper WIDTH-1 bits are stored.
    assign w_result = {w_dbit, r_sh};

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the default assignment first means every path drives w_state_nxt,
    // so no latch is inferred even if a case arm forgets to assign it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_nxt = SHIFT;
            SHIFT:   if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = start ? SHIFT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sh     <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= bin;
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (r_state == SHIFT) begin
            r_sh  <= w_result[WIDTH-1:1];
            r_br  <= w_br_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_diff   <= w_result;
                r_borrow <= w_br_nxt;
                r_ovf    <= (r_a[MSB] != r_b[MSB]) && (w_result[MSB] != r_a[MSB]);
            end
        end
    end

    assign busy   = (r_state == SHIFT);
    assign done   = (r_state == DONE);
    assign diff   = r_diff;
    assign borrow = r_borrow;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_serial_subtractor4.sv
// Directed testbench for serial_subtractor4 (WIDTH=4): reset, vectors, back-to-back,
// abort by reset, and an exhaustive cross-check against the adder identity.
module tb_serial_subtractor4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [3:0] diff;
    logic       borrow;
    logic       ovf;

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor4 #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents an operation for one accepting edge; caller must be idle or in DONE.
    task automatic start_op(input logic [3:0] ta, input logic [3:0] tb, input logic tbin);
        start = 1'b1;
        a     = ta;
        b     = tb;
        bin   = tbin;
        step();
        start = 1'b0;
    endtask

    // Advances until done, reporting edges taken and busy cycles seen.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = 0;
        while (!done && edges < 20) begin
            if (busy) busy_cycles++;
            step();
            edges++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_timeout: done=%b after %0d edges, required 1", done, edges);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        step();
        step();
        n_checks++;
        if ({busy, done, diff, borrow, ovf} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b diff=%b borrow=%b ovf=%b, required all 0",
                     busy, done, diff, borrow, ovf);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int edges;
        int bc;
        start_op(4'b0101, 4'b0011, 1'b0);
        wait_done(edges, bc);
        n_checks++;
        if (edges !== 4) begin
            n_fail++;
            $display("FAIL basic_latency: %0d edges, required 4", edges);
        end
        n_checks++;
        if (bc !== 4) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: %0d, required 4", bc);
        end
        n_checks++;
        if ({diff, borrow, ovf} !== {4'b0010, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_result: diff=%b borrow=%b ovf=%b, required 0010 0 0", diff, borrow, ovf);
        end
        step();
        n_checks++;
        if ({done, busy, diff} !== {1'b0, 1'b0, 4'b0010}) begin
            n_fail++;
            $display("FAIL basic_pulse_hold: done=%b busy=%b diff=%b, required 0 0 0010", done, busy, diff);
        end
    endtask

    task automatic test_vectors();
        logic [3:0] va   [4] = '{4'b0000, 4'b0101, 4'b1000, 4'b0111};
        logic [3:0] vb   [4] = '{4'b0000, 4'b1111, 4'b0001, 4'b1111};
        logic       vbin [4] = '{1'b1,    1'b0,    1'b0,    1'b0};
        logic [3:0] ed   [4] = '{4'b1111, 4'b0110, 4'b0111, 4'b1000};
        logic       eb   [4] = '{1'b1,    1'b1,    1'b0,    1'b1};
        logic       eo   [4] = '{1'b0,    1'b0,    1'b1,    1'b1};
        int edges;
        int bc;
        for (int i = 0; i < 4; i++) begin
            start_op(va[i], vb[i], vbin[i]);
            wait_done(edges, bc);
            n_checks++;
            if ({diff, borrow, ovf} !== {ed[i], eb[i], eo[i]}) begin
                n_fail++;
                $display("FAIL vector_%0d: diff=%b borrow=%b ovf=%b, required %b %b %b",
                         i, diff, borrow, ovf, ed[i], eb[i], eo[i]);
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        int edges;
        int bc;
        int gap;
        start = 1'b1;
        a     = 4'b1001;
        b     = 4'b0011;
        bin   = 1'b0;
        step();
        a = 4'b1111;
        b = 4'b1111;
        wait_done(edges, bc);
        n_checks++;
        if ({diff, borrow, ovf} !== {4'b0110, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_first: diff=%b borrow=%b ovf=%b, required 0110 0 1", diff, borrow, ovf);
        end
        gap = 0;
        do begin
            step();
            gap++;
            if (gap == 2) begin
                n_checks++;
                if ({busy, done, diff} !== {1'b1, 1'b0, 4'b0110}) begin
                    n_fail++;
                    $display("FAIL b2b_hold_in_shift: busy=%b done=%b diff=%b, required 1 0 0110",
                             busy, done, diff);
                end
            end
        end while (!done && gap < 20);
        start = 1'b0;
        n_checks++;
        if (gap !== 5) begin
            n_fail++;
            $display("FAIL b2b_spacing: %0d cycles between done pulses, required 5", gap);
        end
        n_checks++;
        if ({diff, borrow, ovf} !== {4'b0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_second: diff=%b borrow=%b ovf=%b, required 0000 0 0", diff, borrow, ovf);
        end
        step();
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_return_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_reset_abort();
        int edges;
        int bc;
        start_op(4'b0111, 4'b1111, 1'b0);
        wait_done(edges, bc);
        step();
        start_op(4'b1010, 4'b0101, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({busy, done, diff, borrow, ovf} !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_clear: busy=%b done=%b diff=%b borrow=%b ovf=%b, required all 0",
                     busy, done, diff, borrow, ovf);
        end
        step();
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_stays_idle: busy=%b done=%b, required 0 0", busy, done);
        end
        start_op(4'b1010, 4'b0101, 1'b0);
        wait_done(edges, bc);
        n_checks++;
        if ({edges, diff, borrow, ovf} !== {32'd4, 4'b0101, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL abort_restart: edges=%0d diff=%b borrow=%b ovf=%b, required 4 0101 0 1",
                     edges, diff, borrow, ovf);
        end
        step();
    endtask

    task automatic test_adder_crosscheck();
        logic [3:0] xa;
        logic [3:0] xb;
        logic       xbin;
        logic [4:0] exp5;
        logic       exp_ovf;
        int         sa;
        int         sb;
        int         r;
        int         edges;
        int         bc;
        for (int i = 0; i < 512; i++) begin
            xa   = 4'(i >> 5);
            xb   = 4'(i >> 1);
            xbin = i[0];
            start_op(xa, xb, xbin);
            wait_done(edges, bc);
            exp5    = {1'b0, xa} + {1'b0, ~xb} + {4'b0000, ~xbin};
            sa      = (xa >= 8) ? int'(xa) - 16 : int'(xa);
            sb      = (xb >= 8) ? int'(xb) - 16 : int'(xb);
            r       = sa - sb - int'(xbin);
            exp_ovf = (r < -8) || (r > 7);
            n_checks++;
            if ({~borrow, diff} !== exp5) begin
                n_fail++;
                $display("FAIL xcheck_sum a=%b b=%b bin=%b: {~borrow,diff}=%b, required %b",
                         xa, xb, xbin, {~borrow, diff}, exp5);
            end
            n_checks++;
            if (ovf !== exp_ovf) begin
                n_fail++;
                $display("FAIL xcheck_ovf a=%b b=%b bin=%b: ovf=%b, required %b",
                         xa, xb, xbin, ovf, exp_ovf);
            end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_back_to_back();
        test_reset_abort();
        test_adder_crosscheck();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
